// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: register 0 is a read-only ID, registers 1..NUM_REGS-1 are byte-strobed R/W.
// Latency: read data one cycle after AR acceptance; write response one cycle after AW+W are both present.
// Backpressure: RVALID/BVALID hold until RREADY/BREADY; AW/W stall while a write response is pending.
module axi_lite_regfile #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 8,
  parameter logic [31:0] ID_VALUE           = 32'hDCBA4321
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(SW);

  localparam logic [AW-1:0] NUM_REGS_A = AW'(NUM_REGS);
  localparam logic [DW-1:0] ID_EXT     = DW'(ID_VALUE);
  localparam logic [1:0]    RESP_OKAY  = 2'b00;
  localparam logic [1:0]    RESP_SLV   = 2'b10;

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  // Register storage (register 0 is a constant and has no flops)
  logic [DW-1:0] r_regs [1:NUM_REGS-1];
  logic [DW-1:0] w_reg_val [NUM_REGS];

  // Ready gating: stays low until the first edge after reset release
  logic r_rst_done;

  // Read path state
  rstate_t       r_rstate;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;

  // Write path state
  logic          r_aw_held;
  logic [AW-1:0] r_awaddr;
  logic          r_w_held;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic [NUM_REGS-1:0] r_wr_pulse;

  // Combinational helpers
  logic          w_arready;
  logic          w_awready;
  logic          w_wready;
  logic [AW-1:0] w_ar_idx;
  logic          w_ar_in_range;
  logic [DW-1:0] w_ar_data;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_commit;
  logic [AW-1:0] w_cm_addr;
  logic [DW-1:0] w_cm_data;
  logic [SW-1:0] w_cm_strb;
  logic [AW-1:0] w_cm_idx;
  logic          w_cm_ok;

  // Present the full register map as a uniform array, ID in slot 0
  always_comb begin
    w_reg_val[0] = ID_EXT;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_reg_val[i] = r_regs[i];
    end
  end

  assign w_arready = r_rst_done && (r_rstate == R_IDLE);
  assign w_awready = r_rst_done && !r_aw_held && !r_bvalid;
  assign w_wready  = r_rst_done && !r_w_held && !r_bvalid;

  assign w_ar_idx      = S_AXI_ARADDR >> ADDR_LSB;
  assign w_ar_in_range = (w_ar_idx < NUM_REGS_A);

  // Read mux over the register map; out-of-range selects zero
  always_comb begin
    w_ar_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == AW'(i)) begin
        w_ar_data = w_reg_val[i];
      end
    end
  end

  // A commit uses whatever of address/data is held, or what handshakes this cycle
  assign w_aw_hs   = S_AXI_AWVALID && w_awready;
  assign w_w_hs    = S_AXI_WVALID && w_wready;
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_cm_addr = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  assign w_cm_data = r_w_held ? r_wdata : S_AXI_WDATA;
  assign w_cm_strb = r_w_held ? r_wstrb : S_AXI_WSTRB;
  assign w_cm_idx  = w_cm_addr >> ADDR_LSB;
  assign w_cm_ok   = (w_cm_idx != '0) && (w_cm_idx < NUM_REGS_A);

  // Arm the ready outputs one edge after reset deasserts
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Read FSM: accept in R_IDLE, hold registered response in R_DATA until taken
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && w_arready) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_in_range ? w_ar_data : '0;
            r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLV;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  // Capture address and data independently until both are available
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
    end
  end

  // Write response and per-register write pulse
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_cm_ok ? RESP_OKAY : RESP_SLV;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (w_cm_ok && (w_cm_idx == AW'(i))) begin
            r_wr_pulse[i] <= 1'b1;
          end
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Byte-strobed update of the writable registers on commit
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_cm_ok) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_cm_idx == AW'(i)) begin
          for (int b = 0; b < SW; b++) begin
            if (w_cm_strb[b]) begin
              r_regs[i][8*b +: 8] <= w_cm_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = w_reg_val[g];
  end

  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed testbench for axi_lite_regfile with default parameters (32-bit data, 8 registers).
// Inputs change and outputs are sampled 1ns after each rising clock edge.
// Every handshake wait is bounded; an expired wait is reported as a failed comparison.
module tb_axi_lite_regfile;

  localparam logic [31:0] ID = 32'hDCBA4321;

  logic        clk;
  logic        rst_n;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [255:0] reg_out;
  logic [7:0]  wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  axi_lite_regfile dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] pulse, output bit ok);
    bit aw_done, w_done, aw_hs, w_hs;
    ok = 0; resp = 2'b11; pulse = 8'hFF;
    aw_done = 0; w_done = 0;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
    for (int k = 0; k < 20; k++) begin
      if (aw_done && w_done) break;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick;
      if (aw_hs) begin awvalid = 0; aw_done = 1; end
      if (w_hs)  begin wvalid = 0;  w_done = 1;  end
    end
    for (int k = 0; k < 20; k++) begin
      if (bvalid) begin
        resp = bresp; pulse = wr_pulse; ok = aw_done && w_done;
        tick;
        break;
      end
      tick;
    end
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit ok);
    bit ar_done, ar_hs;
    ok = 0; d = 32'hFFFF_FFFF; resp = 2'b11; ar_done = 0;
    araddr = a; arvalid = 1; rready = 1;
    for (int k = 0; k < 20; k++) begin
      ar_hs = arvalid && arready;
      tick;
      if (ar_hs) begin arvalid = 0; ar_done = 1; break; end
    end
    for (int k = 0; k < 20; k++) begin
      if (rvalid) begin
        d = rdata; resp = rresp; ok = ar_done;
        tick;
        break;
      end
      tick;
    end
    arvalid = 0; rready = 0;
  endtask

  task automatic test_reset;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) tick;
    n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL reset_arready: got %0b want 0", arready); end
    n_cmp++; if ({awready, wready} !== 2'b00) begin n_err++; $display("FAIL reset_aw_w_ready: got %b want 00", {awready, wready}); end
    n_cmp++; if ({rvalid, bvalid} !== 2'b00) begin n_err++; $display("FAIL reset_valids: got %b want 00", {rvalid, bvalid}); end
    n_cmp++; if ({rdata, rresp, bresp} !== 36'h0) begin n_err++; $display("FAIL reset_data_resp: got %h want 0", {rdata, rresp, bresp}); end
    n_cmp++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL reset_wr_pulse: got %h want 00", wr_pulse); end
    n_cmp++; if (reg_out !== {224'h0, ID}) begin n_err++; $display("FAIL reset_reg_out: got %h want %h", reg_out, {224'h0, ID}); end
    rst_n = 1;
    #1;
    n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL release_arready_early: got %0b want 0", arready); end
    tick;
    n_cmp++; if ({arready, awready, wready} !== 3'b111) begin n_err++; $display("FAIL release_readies: got %b want 111", {arready, awready, wready}); end
  endtask

  task automatic test_id_read;
    araddr = 6'h00; arvalid = 1; rready = 0;
    tick;
    arvalid = 0;
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL id_rvalid: got %0b want 1", rvalid); end
    n_cmp++; if (rdata !== ID) begin n_err++; $display("FAIL id_rdata: got %h want %h", rdata, ID); end
    n_cmp++; if (rresp !== 2'b00) begin n_err++; $display("FAIL id_rresp: got %b want 00", rresp); end
    n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL id_arready_busy: got %0b want 0", arready); end
    rready = 1;
    tick;
    rready = 0;
    n_cmp++; if ({rvalid, arready} !== 2'b01) begin n_err++; $display("FAIL id_after_hs: got %b want 01", {rvalid, arready}); end
  endtask

  task automatic test_write_strobe;
    logic [1:0] resp; logic [7:0] pulse; logic [31:0] d; bit ok;
    do_write(6'h04, 32'h12345678, 4'hF, resp, pulse, ok);
    n_cmp++; if (!ok || resp !== 2'b00) begin n_err++; $display("FAIL wr1_bresp: got %b ok=%0b want 00", resp, ok); end
    n_cmp++; if (pulse !== 8'h02) begin n_err++; $display("FAIL wr1_pulse: got %h want 02", pulse); end
    n_cmp++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL wr1_pulse_len: got %h want 00", wr_pulse); end
    do_read(6'h04, d, resp, ok);
    n_cmp++; if (!ok || d !== 32'h12345678 || resp !== 2'b00) begin n_err++; $display("FAIL rd1: got %h/%b want 12345678/00", d, resp); end
    do_write(6'h04, 32'hAABBCCDD, 4'h2, resp, pulse, ok);
    n_cmp++; if (!ok || resp !== 2'b00) begin n_err++; $display("FAIL wr_strb_bresp: got %b want 00", resp); end
    do_read(6'h04, d, resp, ok);
    n_cmp++; if (!ok || d !== 32'h1234CC78) begin n_err++; $display("FAIL rd_strb: got %h want 1234cc78", d); end
    n_cmp++; if (reg_out[63:32] !== 32'h1234CC78) begin n_err++; $display("FAIL reg_out1: got %h want 1234cc78", reg_out[63:32]); end
    // Low byte-offset bits are ignored: 0x0B addresses register 2
    do_write(6'h0B, 32'h0BADF00D, 4'hF, resp, pulse, ok);
    n_cmp++; if (!ok || pulse !== 8'h04) begin n_err++; $display("FAIL unaligned_pulse: got %h want 04", pulse); end
    do_read(6'h08, d, resp, ok);
    n_cmp++; if (!ok || d !== 32'h0BADF00D) begin n_err++; $display("FAIL unaligned_rd: got %h want 0badf00d", d); end
  endtask

  task automatic test_split_backpressure;
    bready = 0;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
    tick;
    wvalid = 0;
    n_cmp++; if ({wready, awready, bvalid} !== 3'b010) begin n_err++; $display("FAIL split_w_held: got %b want 010", {wready, awready, bvalid}); end
    tick; tick;
    awaddr = 6'h0C; awvalid = 1;
    tick;
    awvalid = 0;
    n_cmp++; if ({bvalid, bresp} !== 3'b100) begin n_err++; $display("FAIL split_commit: got %b want 100", {bvalid, bresp}); end
    n_cmp++; if (wr_pulse !== 8'h08) begin n_err++; $display("FAIL split_pulse: got %h want 08", wr_pulse); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++; if ({bvalid, awready, wready, wr_pulse} !== {3'b100, 8'h00}) begin
        n_err++; $display("FAIL split_hold%0d: got %b/%h want 100/00", k, {bvalid, awready, wready}, wr_pulse);
      end
    end
    bready = 1;
    tick;
    bready = 0;
    n_cmp++; if ({bvalid, awready, wready} !== 3'b011) begin n_err++; $display("FAIL split_release: got %b want 011", {bvalid, awready, wready}); end
    n_cmp++; if (reg_out[127:96] !== 32'hCAFEF00D) begin n_err++; $display("FAIL split_reg3: got %h want cafef00d", reg_out[127:96]); end
  endtask

  task automatic test_errors;
    logic [1:0] resp; logic [7:0] pulse; logic [31:0] d; bit ok;
    do_read(6'h20, d, resp, ok);
    n_cmp++; if (!ok || d !== 32'h0 || resp !== 2'b10) begin n_err++; $display("FAIL oor_read: got %h/%b want 0/10", d, resp); end
    do_write(6'h00, 32'hFFFFFFFF, 4'hF, resp, pulse, ok);
    n_cmp++; if (!ok || resp !== 2'b10 || pulse !== 8'h00) begin n_err++; $display("FAIL wr_reg0: got %b/%h want 10/00", resp, pulse); end
    do_write(6'h3C, 32'h11111111, 4'hF, resp, pulse, ok);
    n_cmp++; if (!ok || resp !== 2'b10 || pulse !== 8'h00) begin n_err++; $display("FAIL wr_oor: got %b/%h want 10/00", resp, pulse); end
    do_read(6'h00, d, resp, ok);
    n_cmp++; if (!ok || d !== ID || resp !== 2'b00) begin n_err++; $display("FAIL id_after_wr: got %h/%b want %h/00", d, resp, ID); end
    n_cmp++; if (reg_out[127:0] !== {32'hCAFEF00D, 32'h0BADF00D, 32'h1234CC78, ID}) begin
      n_err++; $display("FAIL err_reg_out: got %h", reg_out[127:0]);
    end
  endtask

  task automatic test_concurrent;
    araddr = 6'h04; arvalid = 1; rready = 0;
    awaddr = 6'h04; awvalid = 1; wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1; bready = 0;
    tick;
    arvalid = 0; awvalid = 0; wvalid = 0;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h1234CC78) begin n_err++; $display("FAIL conc_rdata: got %0b/%h want 1/1234cc78", rvalid, rdata); end
    n_cmp++; if (bvalid !== 1'b1 || wr_pulse !== 8'h02) begin n_err++; $display("FAIL conc_b: got %0b/%h want 1/02", bvalid, wr_pulse); end
    n_cmp++; if (reg_out[63:32] !== 32'h55667788) begin n_err++; $display("FAIL conc_reg1: got %h want 55667788", reg_out[63:32]); end
    rready = 1; bready = 1;
    tick;
    rready = 0; bready = 0;
    n_cmp++; if ({rvalid, bvalid} !== 2'b00) begin n_err++; $display("FAIL conc_done: got %b want 00", {rvalid, bvalid}); end
  endtask

  task automatic test_hold_and_reset;
    araddr = 6'h0C; arvalid = 1; rready = 0;
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1;
    tick;
    arvalid = 0; wvalid = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++; if ({rvalid, arready} !== 2'b10 || rdata !== 32'hCAFEF00D) begin
        n_err++; $display("FAIL rhold%0d: got %b/%h want 10/cafef00d", k, {rvalid, arready}, rdata);
      end
    end
    rst_n = 0;
    #1;
    n_cmp++; if ({rvalid, arready, wready, bvalid} !== 4'b0000 || rdata !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got %b/%h want 0000/0", {rvalid, arready, wready, bvalid}, rdata);
    end
    n_cmp++; if (reg_out !== {224'h0, ID}) begin n_err++; $display("FAIL async_reset_regs: got %h", reg_out); end
    tick; tick;
    rst_n = 1;
    tick;
    n_cmp++; if ({arready, awready, wready} !== 3'b111) begin n_err++; $display("FAIL rerelease_readies: got %b want 111", {arready, awready, wready}); end
    awaddr = 6'h08; awvalid = 1; bready = 1;
    tick;
    awvalid = 0;
    tick;
    n_cmp++; if (bvalid !== 1'b0 || reg_out[95:64] !== 32'h0) begin
      n_err++; $display("FAIL aborted_w: got bvalid=%0b reg2=%h want 0/0", bvalid, reg_out[95:64]);
    end
    bready = 0;
  endtask

  initial begin
    test_reset;
    test_id_read;
    test_write_strobe;
    test_split_backpressure;
    test_errors;
    test_concurrent;
    test_hold_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (32 or 64 only).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width; SHALL satisfy 2^C_S_AXI_ADDR_WIDTH >= NUM_REGS*(C_S_AXI_DATA_WIDTH/8).
REQ-003 SHALL have parameter NUM_REGS, default 8, number of word registers (range 2..64).
REQ-004 SHALL have parameter ID_VALUE, default 32'hDCBA4321, read-only content of register 0 (zero-extended to data width).
REQ-005 SHALL have ports, in this order:
  S_AXI_ACLK  in  1  clock; all logic on its rising edge
  S_AXI_ARESETN  in  1  reset; asynchronous, active-low
  S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR/1/1  write address channel
  S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA/DATA/8/1/1  write data channel
  S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
  S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR/1/1  read address channel
  S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA/2/1/1  read data channel
  reg_out  out  NUM_REGS*DATA  flat register contents, register i at bits [i*DATA +: DATA]
  wr_pulse  out  NUM_REGS  one-cycle pulse per register written

Function
REQ-006 Word index SHALL be addr >> log2(DATA/8); low byte-offset bits ignored; index >= NUM_REGS is out-of-range.
REQ-007 Register 0 SHALL always read ID_VALUE; registers 1..NUM_REGS-1 SHALL be read/write.
REQ-008 Read FSM states R_IDLE, R_DATA: ARREADY=1 only in R_IDLE; ARVALID in R_IDLE -> R_DATA next edge with RVALID=1, RDATA/RRESP registered.
REQ-009 Read response: in-range -> RDATA=register value at acceptance edge, RRESP=2'b00; out-of-range -> RDATA=0, RRESP=2'b10 (SLVERR).
REQ-010 RVALID, RDATA, RRESP SHALL be held stable until RVALID&&RREADY; then R_DATA -> R_IDLE; read throughput max one per 2 cycles.
REQ-011 Write address and data SHALL be captured independently: AWREADY=1 while no address held and BVALID=0; WREADY=1 while no data held and BVALID=0.
REQ-012 Commit SHALL occur on the edge where both address and data are available (held or handshaking that cycle, incl. same-cycle AW+W); BVALID=1 from the next cycle; held-address/data flags cleared.
REQ-013 Commit to in-range register 1..NUM_REGS-1 SHALL update only byte lanes with WSTRB bit set; BRESP=2'b00; WSTRB=0 SHALL leave register unchanged, BRESP=2'b00.
REQ-014 Commit to register 0 or out-of-range SHALL change nothing, BRESP=2'b10, no wr_pulse.
REQ-015 wr_pulse[i] SHALL be 1 for exactly the cycle following a valid commit to register i (same cycle BVALID rises), else 0.
REQ-016 BVALID/BRESP SHALL hold until BVALID&&BREADY; AWREADY/WREADY low meanwhile; one outstanding write max.
REQ-017 Simultaneous read acceptance and write commit to the same register SHALL return pre-write value.
REQ-018 Read and write paths SHALL operate concurrently without mutual stalls.
REQ-019 reg_out SHALL reflect register values registered (no combinational path from AXI inputs).

Reset
REQ-020 S_AXI_ARESETN low SHALL immediately force: ARREADY=0, RVALID=0, RDATA=0, RRESP=0, BVALID=0, BRESP=0, AWREADY=0, WREADY=0, wr_pulse=0, registers 1..N-1=0, held flags cleared, FSM R_IDLE.
REQ-021 Reset asserted mid-transaction SHALL abort it; no partial register update.
REQ-022 ARREADY/AWREADY/WREADY SHALL rise on the first rising edge after reset deassertion.

Verification
REQ-023 Read addr 0x0 -> RVALID next cycle, RDATA=0xDCBA4321, RRESP=00.
REQ-024 Write addr 0x4, WDATA=0x12345678, WSTRB=0xF, AW+W same cycle -> BRESP=00, wr_pulse[1]=1 one cycle, read 0x4 returns 0x12345678; then WDATA=0xAABBCCDD, WSTRB=0x2 -> 0x1234CC78.
REQ-025 W 3 cycles before AW, BREADY low 4 cycles -> single commit, BVALID held, AWREADY/WREADY low until B handshake.
REQ-026 Read 0x20 and write 0x0 (NUM_REGS=8) -> RRESP=10, RDATA=0; BRESP=10; register 0 still ID_VALUE; no wr_pulse.
REQ-027 RREADY low 5 cycles -> RDATA stable, ARREADY=0; reset asserted during held RVALID -> RVALID=0 immediately, registers 0 after release.
